nbit_serial_subtractor: RTL

- Bit-serial N-bit subtractor computing D = A − B − bin, one bit per clock, LSB first.
- The datapath is a single 1-bit full_adder cell: b bit inverted, cin = ~borrow.
- Trades the N-cell parallel adder's area for N+1 cycles of latency.
- Used in the ALU slow path and in area-constrained datapaths; start/busy/done handshake toward the controlling FSM.

---
 rtl/nbit_serial_subtractor.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/nbit_serial_subtractor.sv
// Bit-serial N-bit subtractor: D = A - B - bin, one bit per clock, LSB first.
// A single 1-bit full-adder cell (b inverted, cin = ~borrow) is reused for
// N cycles; a start/busy/done handshake hands operands in and results out.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - operation request, honoured only while busy=0
//   a, b   - minuend / subtrahend, captured when start is accepted
//   bin    - borrow-in, captured when start is accepted
//   busy   - high while bits are being processed
//   done   - one-cycle pulse when the result registers update
//   d      - registered difference
//   bout   - registered borrow-out (unsigned underflow)
//   ovf    - registered two's-complement overflow
//   zero   - registered d == 0 flag
module nbit_serial_subtractor #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] d,
  output logic         bout,
  output logic         ovf,
  output logic         zero
);

  localparam int unsigned CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [N-1:0]  sa, sa_n;
  logic [N-1:0]  sb, sb_n;
  logic [N-1:0]  pr, pr_n;
  logic          br, br_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          busy_n, done_n;
  logic [N-1:0]  d_n;
  logic          bout_n, ovf_n, zero_n;

  // Full-adder cell: sa + ~sb + ~br; sum is the difference bit, ~carry the borrow
  logic [1:0] fa;
  logic       di;
  logic       bo;
  logic       last;

  always_comb begin
    fa   = 2'({1'b0, sa[0]}) + 2'({1'b0, ~sb[0]}) + 2'({1'b0, ~br});
    di   = fa[0];
    bo   = ~fa[1];
    last = (cnt == CW'(N - 1));
  end

  // Next-state and next-output logic
  always_comb begin
    state_n = state;
    sa_n    = sa;
    sb_n    = sb;
    pr_n    = pr;
    br_n    = br;
    cnt_n   = cnt;
    d_n     = d;
    bout_n  = bout;
    ovf_n   = ovf;
    zero_n  = zero;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          sa_n    = a;
          sb_n    = b;
          br_n    = bin;
          cnt_n   = '0;
          state_n = SHIFT;
        end else begin
          state_n = IDLE;
        end
      end

      SHIFT: begin
        sa_n  = sa >> 1;
        sb_n  = sb >> 1;
        // Shift the new bit into the MSB; the concatenation keeps N=1 legal
        pr_n  = N'({di, pr} >> 1);
        br_n  = bo;
        cnt_n = CW'(cnt + 1'b1);
        if (last) begin
          state_n = DONE;
          d_n     = pr_n;
          bout_n  = bo;
          // br here is the borrow into the MSB, so overflow is borrow-in ^ borrow-out
          ovf_n   = br ^ bo;
          zero_n  = (pr_n == '0);
        end
      end

      default: state_n = IDLE;
    endcase

    busy_n = (state_n == SHIFT);
    done_n = (state_n == DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      pr    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      d     <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      state <= state_n;
      sa    <= sa_n;
      sb    <= sb_n;
      pr    <= pr_n;
      br    <= br_n;
      cnt   <= cnt_n;
      busy  <= busy_n;
      done  <= done_n;
      d     <= d_n;
      bout  <= bout_n;
      ovf   <= ovf_n;
      zero  <= zero_n;
    end
  end

endmodule
